// File: rtl/cr_fifo_wr_arb.sv
// Packet-aware round-robin arbiter that merges N_REQ word streams into a
// single FIFO write port, holding the grant until end-of-packet or a word timeout.
module cr_fifo_wr_arb #(
    parameter int N_REQ         = 4,
    parameter int N_DATA_BITS   = 64,
    parameter int MAX_PKT_WORDS = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_REQ-1:0]             req_valid,
    input  logic [N_REQ*N_DATA_BITS-1:0] req_data,
    input  logic [N_REQ-1:0]             req_eop,
    output logic [N_REQ-1:0]             req_ready,
    output logic [N_DATA_BITS-1:0]       fifo_wdata,
    output logic                         fifo_wen,
    input  logic                         fifo_full,
    input  logic                         fifo_afull,
    output logic [2:0]                   grant_id,
    output logic                         err_overflow,
    output logic                         err_timeout
);

    typedef enum logic {IDLE, LOCK} state_t;

    state_t                   state_reg, state_next;
    logic [2:0]               rr_ptr_reg, rr_ptr_next;
    logic [2:0]               grant_id_reg, grant_id_next;
    logic [7:0]               word_cnt_reg, word_cnt_next;
    logic                     fifo_wen_reg;
    logic [N_DATA_BITS-1:0]   fifo_wdata_reg, fifo_wdata_next;
    logic                     err_overflow_reg;
    logic                     err_timeout_reg, err_timeout_next;

    // Requester inputs padded to 8 entries so a 3-bit index is always in range.
    logic [N_DATA_BITS-1:0]   data_arr [8];
    logic [7:0]               eop_pad;
    logic [15:0]              valid_pad;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_unpack
            if (gi < N_REQ) begin : g_used
                assign data_arr[gi] = req_data[gi*N_DATA_BITS +: N_DATA_BITS];
            end else begin : g_pad
                assign data_arr[gi] = '0;
            end
        end
    endgenerate

    assign eop_pad   = 8'(req_eop);
    assign valid_pad = 16'(req_valid);

    // Round-robin search: walk downward so the lowest offset from rr_ptr wins.
    logic [2:0] sel_idx;
    logic       sel_found;
    logic [3:0] probe;

    always_comb begin
        sel_idx   = '0;
        sel_found = 1'b0;
        probe     = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            probe = {1'b0, rr_ptr_reg} + 4'(k);
            if (probe >= 4'(N_REQ))
                probe = probe - 4'(N_REQ);
            if (valid_pad[probe]) begin
                sel_found = 1'b1;
                sel_idx   = probe[2:0];
            end
        end
    end

    logic [2:0] active_idx;
    logic       have_cand;
    logic       flow_ok;
    logic       accept;
    logic       accept_eop;
    logic [7:0] cnt_inc;
    logic [2:0] ptr_after;

    assign active_idx = (state_reg == LOCK) ? grant_id_reg : sel_idx;
    assign have_cand  = (state_reg == LOCK) || sel_found;
    assign flow_ok    = !fifo_afull && !fifo_full && !rst;
    assign accept     = flow_ok && have_cand && valid_pad[{1'b0, active_idx}];
    assign accept_eop = eop_pad[active_idx];
    assign cnt_inc    = (state_reg == IDLE) ? 8'd1 : word_cnt_reg + 8'd1;
    assign ptr_after  = (active_idx == 3'(N_REQ - 1)) ? 3'd0 : active_idx + 3'd1;

    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_ready
            assign req_ready[gi] = flow_ok && have_cand && (active_idx == 3'(gi));
        end
    endgenerate

    always_comb begin
        state_next       = state_reg;
        rr_ptr_next      = rr_ptr_reg;
        grant_id_next    = grant_id_reg;
        word_cnt_next    = word_cnt_reg;
        fifo_wdata_next  = fifo_wdata_reg;
        err_timeout_next = err_timeout_reg;

        if (state_reg == IDLE && sel_found)
            grant_id_next = sel_idx;

        if (accept) begin
            fifo_wdata_next = data_arr[active_idx];
            if (accept_eop) begin
                state_next    = IDLE;
                rr_ptr_next   = ptr_after;
                word_cnt_next = '0;
            end else if (cnt_inc >= 8'(MAX_PKT_WORDS)) begin
                // Packet ran too long: drop the lock and let others in.
                state_next       = IDLE;
                rr_ptr_next      = ptr_after;
                word_cnt_next    = '0;
                err_timeout_next = 1'b1;
            end else begin
                state_next    = LOCK;
                word_cnt_next = cnt_inc;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= IDLE;
            rr_ptr_reg       <= '0;
            grant_id_reg     <= '0;
            word_cnt_reg     <= '0;
            fifo_wen_reg     <= 1'b0;
            fifo_wdata_reg   <= '0;
            err_overflow_reg <= 1'b0;
            err_timeout_reg  <= 1'b0;
        end else begin
            state_reg        <= state_next;
            rr_ptr_reg       <= rr_ptr_next;
            grant_id_reg     <= grant_id_next;
            word_cnt_reg     <= word_cnt_next;
            fifo_wen_reg     <= accept;
            fifo_wdata_reg   <= fifo_wdata_next;
            err_overflow_reg <= err_overflow_reg | (fifo_wen_reg & fifo_full);
            err_timeout_reg  <= err_timeout_next;
        end
    end

    assign fifo_wen     = fifo_wen_reg;
    assign fifo_wdata   = fifo_wdata_reg;
    assign grant_id     = grant_id_reg;
    assign err_overflow = err_overflow_reg;
    assign err_timeout  = err_timeout_reg;

endmodule

// File: doc/cr_fifo_wr_arb.md
CR_FIFO_WR_ARB -- requirements
Module: cr_fifo_wr_arb

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters, 2..8.
REQ-002 Parameter N_DATA_BITS, default 64: data width per requester and at the FIFO write port.
REQ-003 Parameter MAX_PKT_WORDS, default 16: lock timeout, in words per grant, 1..255.
REQ-004 Port clk  input  1  sole clock; all state is rising-edge clocked.
REQ-005 Port rst  input  1  asynchronous, active-high reset.
REQ-006 Port req_valid  input  N_REQ  per-requester word valid.
REQ-007 Port req_data  input  N_REQ*N_DATA_BITS  requester i occupies bits [i*N_DATA_BITS +: N_DATA_BITS].
REQ-008 Port req_eop  input  N_REQ  last word of a packet, qualified by req_valid.
REQ-009 Port req_ready  output  N_REQ  word accepted when req_valid[i] & req_ready[i].
REQ-010 Port fifo_wdata  output  N_DATA_BITS  FIFO write data, registered.
REQ-011 Port fifo_wen  output  1  FIFO write enable, registered.
REQ-012 Port fifo_full  input  1  FIFO full flag.
REQ-013 Port fifo_afull  input  1  FIFO almost-full flag; the FIFO almost-full threshold is at least 1.
REQ-014 Port grant_id  output  3  index of the requester currently owning the port.
REQ-015 Port err_overflow  output  1  sticky: write issued while fifo_full.
REQ-016 Port err_timeout  output  1  sticky: a lock was force-released.

Function
REQ-017 States: IDLE and LOCK.
REQ-018 IDLE: select the first requester with req_valid set, searching round-robin from rr_ptr upward with modulo N_REQ wrap; the result is grant_id, registered on the next edge.
REQ-019 A word is accepted only when fifo_afull=0 and fifo_full=0; otherwise every req_ready is 0.
REQ-020 req_ready is a combinational function of the state, the selection, and the FIFO flags; at most one bit is set per cycle.
REQ-021 Accepting a word with eop=0 in IDLE moves the block to LOCK with the winner latched.
REQ-022 Accepting a word with eop=1 in IDLE is a single-word packet; the block stays in IDLE.
REQ-023 LOCK: only the latched requester may receive req_ready; other requesters are ignored.
REQ-024 Accepting the eop word in LOCK returns the block to IDLE.
REQ-025 Whenever a packet completes, rr_ptr is set to (winner+1) mod N_REQ.
REQ-026 A word counter counts the words accepted in the current grant, including the first word.
REQ-027 When the word counter reaches MAX_PKT_WORDS without eop, the block force-releases the lock:
- returns to IDLE on that cycle's edge;
- sets err_timeout;
- advances rr_ptr.
REQ-028 Write latency is exactly 1 cycle: a word accepted at edge t appears as fifo_wen=1 with its data in the cycle following edge t.
REQ-029 fifo_wen is 0 in any cycle that follows a cycle with no acceptance.
REQ-030 fifo_wdata holds its last value when fifo_wen=0.
REQ-031 err_overflow is set if fifo_wen=1 while fifo_full=1; this indicates a FIFO almost-full threshold misconfiguration.
REQ-032 The sticky error bits clear only on reset.
REQ-033 A requester that drops req_valid mid-packet in LOCK keeps the lock; the block stalls until that requester resumes or the timeout expires.
REQ-034 If req_valid and fifo_afull rise in the same cycle, fifo_afull wins and no word is accepted.

Reset
REQ-035 On rst, asynchronously and immediately:
- state=IDLE, rr_ptr=0, word counter=0;
- grant_id=0, fifo_wen=0, fifo_wdata=0;
- err_overflow=0, err_timeout=0.
REQ-036 req_ready reads 0 while rst=1.
REQ-037 A packet interrupted by reset is dropped with no eop emitted; after rst deasserts, arbitration restarts from requester 0.

Verification
REQ-038 Two single-word packets, with req_valid=4'b1010 held steady, rr_ptr=0, and FIFO not full: expect grants to requester 1 then requester 3, and fifo_wen high for 2 consecutive cycles starting 1 cycle after the first acceptance.
REQ-039 Requester 0 sends a 3-word packet while requester 2 is also valid: expect requester 2 to receive no req_ready until requester 0's eop is accepted, then requester 2 granted next; fifo_wdata order is R0w0, R0w1, R0w2, R2w0.
REQ-040 fifo_afull asserted mid-packet for 5 cycles: expect req_ready=0 and fifo_wen=0 from the following cycle, and err_overflow stays 0.
REQ-041 MAX_PKT_WORDS=4, requester 1 sends 6 words with no eop: expect a forced return to IDLE after the 4th word, err_timeout=1, and the next grant to requester 2 if it is valid.
REQ-042 rst pulsed while in LOCK after 2 words: expect fifo_wen=0, grant_id=0, state IDLE, and the next grant to the lowest-index valid requester.
REQ-043 Force fifo_full=1 with fifo_afull=0 (illegal configuration) during a write: expect err_overflow=1 and it remains set until rst.
